// File: rtl/control_unit_v2.sv
// control_unit_v2: two-byte fetch / execute sequencer with valid/ready flash
// and SRAM handshakes, latched ALU flags, a CALL/RET return stack, HALT/resume
// and a registered GPIO output.
//
// state     | meaning
// ----------+---------------------------------------------------------
// FETCH_HI  | request flash, latch instruction[15:8] on flash_valid
// FETCH_LO  | request flash, latch instruction[7:0] on flash_valid
// EXEC      | decode and execute; boot IN may stall here for flash
// MEM_WAIT  | hold SRAM request stable until sram_ready
// HALT      | no requests; resume returns to FETCH_HI
module control_unit_v2 #(
    parameter int DW          = 8,
    parameter int PCW         = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic [7:0]     flash_data,
    input  logic           flash_valid,
    output logic           flash_req,
    input  logic [PCW-1:0] pc_cur,
    output logic           pc_inc,
    output logic           pc_load,
    output logic [PCW-1:0] pc_next,
    output logic [3:0]     reg_read_addr_a,
    output logic [3:0]     reg_read_addr_b,
    input  logic [DW-1:0]  reg_read_data_a,
    input  logic [DW-1:0]  reg_read_data_b,
    output logic           reg_write_en,
    output logic [3:0]     reg_write_addr,
    output logic [DW-1:0]  reg_write_data,
    output logic [2:0]     alu_opcode,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_equal,
    input  logic           alu_carry,
    output logic           sram_req,
    output logic           sram_we,
    output logic [7:0]     sram_addr,
    output logic [DW-1:0]  sram_wdata,
    input  logic [DW-1:0]  sram_rdata,
    input  logic           sram_ready,
    input  logic [DW-1:0]  in_gpio,
    input  logic           bootstrapping,
    output logic [DW-1:0]  out_gpio,
    input  logic           resume,
    output logic           halted,
    output logic           stack_err,
    output logic [2:0]     state,
    output logic [15:0]    instruction
);
    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH_HI = 3'd0,
        S_FETCH_LO = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_instr;
    logic             r_z;
    logic             r_c;
    logic [SPW-1:0]   r_sp;
    logic             r_stack_err;
    logic [DW-1:0]    r_out_gpio;
    logic [PCW-1:0]   r_stack [STACK_DEPTH];

    logic [3:0]       w_op;
    logic [3:0]       w_dst;
    logic [PCW-1:0]   w_tgt;
    logic [PCW-1:0]   w_call_tgt;
    logic [AW-1:0]    w_pop_idx;
    logic             w_push;
    logic             w_pop;
    logic             w_err_set;
    logic             w_flags_we;
    logic             w_out_we;

    assign w_op       = r_instr[15:12];
    assign w_dst      = r_instr[11:8];
    assign w_tgt      = PCW'(r_instr[11:0]);
    assign w_call_tgt = {pc_cur[PCW-1:8], r_instr[7:0]};
    assign w_pop_idx  = r_sp[AW-1:0] - AW'(1);

    // STORE and OUT read the register named by the dst field
    assign reg_read_addr_a = (w_op == 4'h2 || w_op == 4'h7) ? w_dst : r_instr[7:4];
    assign reg_read_addr_b = r_instr[3:0];

    assign halted      = (r_state == S_HALT);
    assign stack_err   = r_stack_err;
    assign out_gpio    = r_out_gpio;
    assign state       = r_state;
    assign instruction = r_instr;

    // Next state and all strobes; everything is forced low while reset is held
    always_comb begin
        w_state_nxt    = r_state;
        flash_req      = 1'b0;
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        pc_next        = '0;
        reg_write_en   = 1'b0;
        reg_write_addr = '0;
        reg_write_data = '0;
        alu_opcode     = '0;
        alu_a          = '0;
        alu_b          = '0;
        sram_req       = 1'b0;
        sram_we        = 1'b0;
        sram_addr      = '0;
        sram_wdata     = '0;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_err_set      = 1'b0;
        w_flags_we     = 1'b0;
        w_out_we       = 1'b0;
        if (arst_n) begin
            case (r_state)
                S_FETCH_HI, S_FETCH_LO: begin
                    flash_req = 1'b1;
                    if (flash_valid) begin
                        pc_inc      = 1'b1;
                        w_state_nxt = (r_state == S_FETCH_HI) ? S_FETCH_LO : S_EXEC;
                    end
                end
                S_EXEC: begin
                    w_state_nxt = S_FETCH_HI;
                    case (w_op)
                        4'h0: begin
                            if (w_dst == 4'h1) begin
                                if (r_sp == '0) begin
                                    w_err_set = 1'b1;
                                end else begin
                                    pc_load = 1'b1;
                                    pc_next = r_stack[w_pop_idx];
                                    w_pop   = 1'b1;
                                end
                            end else if (w_dst == 4'h2) begin
                                w_state_nxt = S_HALT;
                            end else if (w_dst == 4'h3) begin
                                if (r_sp == SP_FULL) begin
                                    w_err_set = 1'b1;
                                end else begin
                                    pc_load = 1'b1;
                                    pc_next = w_call_tgt;
                                    w_push  = 1'b1;
                                end
                            end
                        end
                        4'h1, 4'h2: begin
                            sram_req   = 1'b1;
                            sram_we    = (w_op == 4'h2);
                            sram_addr  = r_instr[7:0];
                            sram_wdata = (w_op == 4'h2) ? reg_read_data_a : '0;
                            if (sram_ready) begin
                                if (w_op == 4'h1) begin
                                    reg_write_en   = 1'b1;
                                    reg_write_addr = w_dst;
                                    reg_write_data = sram_rdata;
                                end
                            end else begin
                                w_state_nxt = S_MEM_WAIT;
                            end
                        end
                        4'h3: begin
                            pc_load = 1'b1;
                            pc_next = w_tgt;
                        end
                        4'h4: begin
                            pc_load = r_z;
                            pc_next = r_z ? w_tgt : '0;
                        end
                        4'h5: begin
                            pc_load = r_c;
                            pc_next = r_c ? w_tgt : '0;
                        end
                        4'h6: begin
                            if (bootstrapping) begin
                                flash_req = 1'b1;
                                if (flash_valid) begin
                                    pc_inc         = 1'b1;
                                    reg_write_en   = 1'b1;
                                    reg_write_addr = w_dst;
                                    reg_write_data = DW'(flash_data);
                                end else begin
                                    w_state_nxt = S_EXEC;
                                end
                            end else begin
                                reg_write_en   = 1'b1;
                                reg_write_addr = w_dst;
                                reg_write_data = in_gpio;
                            end
                        end
                        4'h7: w_out_we = 1'b1;
                        default: begin
                            alu_opcode     = w_op[2:0];
                            alu_a          = reg_read_data_a;
                            alu_b          = reg_read_data_b;
                            reg_write_en   = 1'b1;
                            reg_write_addr = w_dst;
                            reg_write_data = alu_result;
                            w_flags_we     = 1'b1;
                        end
                    endcase
                end
                S_MEM_WAIT: begin
                    sram_req   = 1'b1;
                    sram_we    = (w_op == 4'h2);
                    sram_addr  = r_instr[7:0];
                    sram_wdata = (w_op == 4'h2) ? reg_read_data_a : '0;
                    if (sram_ready) begin
                        w_state_nxt = S_FETCH_HI;
                        if (w_op == 4'h1) begin
                            reg_write_en   = 1'b1;
                            reg_write_addr = w_dst;
                            reg_write_data = sram_rdata;
                        end
                    end
                end
                S_HALT: begin
                    if (resume) w_state_nxt = S_FETCH_HI;
                end
                default: w_state_nxt = S_FETCH_HI;
            endcase
        end
    end

    // State, instruction latch, flags, stack pointer, error and GPIO registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_FETCH_HI;
            r_instr     <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_sp        <= '0;
            r_stack_err <= 1'b0;
            r_out_gpio  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_FETCH_HI && flash_valid) r_instr[15:8] <= flash_data;
            if (r_state == S_FETCH_LO && flash_valid) r_instr[7:0]  <= flash_data;
            if (w_flags_we) begin
                r_z <= alu_equal;
                r_c <= alu_carry;
            end
            if (w_push)     r_sp <= r_sp + SPW'(1);
            else if (w_pop) r_sp <= r_sp - SPW'(1);
            if (w_err_set)  r_stack_err <= 1'b1;
            if (w_out_we)   r_out_gpio  <= reg_read_data_a;
        end
    end

    // Return-stack storage; contents survive errors and need no reset
    always_ff @(posedge clk) begin
        if (w_push) r_stack[r_sp[AW-1:0]] <= pc_cur;
    end
endmodule

// File: tb/tb_control_unit_v2.sv
// Bench for control_unit_v2: surrounds the sequencer with flash, PC, register
// file, ALU and SRAM models, and checks it against an instruction-level model.
module tb_control_unit_v2;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [7:0]  flash_data;
    logic        flash_valid, flash_req;
    logic [11:0] pc_cur, pc_next;
    logic        pc_inc, pc_load;
    logic [3:0]  reg_read_addr_a, reg_read_addr_b, reg_write_addr;
    logic [7:0]  reg_read_data_a, reg_read_data_b, reg_write_data;
    logic        reg_write_en;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic        alu_equal, alu_carry;
    logic        sram_req, sram_we, sram_ready;
    logic [7:0]  sram_addr, sram_wdata, sram_rdata;
    logic [7:0]  in_gpio = 8'h00;
    logic        bootstrapping = 1'b0;
    logic [7:0]  out_gpio;
    logic        resume = 1'b0;
    logic        halted, stack_err;
    logic [2:0]  state;
    logic [15:0] instruction;

    control_unit_v2 #(.DW(8), .PCW(12), .STACK_DEPTH(4)) dut (
        .clk(clk), .arst_n(arst_n),
        .flash_data(flash_data), .flash_valid(flash_valid), .flash_req(flash_req),
        .pc_cur(pc_cur), .pc_inc(pc_inc), .pc_load(pc_load), .pc_next(pc_next),
        .reg_read_addr_a(reg_read_addr_a), .reg_read_addr_b(reg_read_addr_b),
        .reg_read_data_a(reg_read_data_a), .reg_read_data_b(reg_read_data_b),
        .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .alu_equal(alu_equal), .alu_carry(alu_carry),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .in_gpio(in_gpio), .bootstrapping(bootstrapping), .out_gpio(out_gpio),
        .resume(resume), .halted(halted), .stack_err(stack_err),
        .state(state), .instruction(instruction)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ALU of the surrounding system: add, sub (borrow as carry), and, or, xor, pass a
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    // ---------------- environment ----------------
    logic [7:0]  fl    [4096];
    logic [7:0]  ireg  [16];
    logic [7:0]  ismem [256];
    logic [7:0]  regs  [16];
    logic [7:0]  smem  [256];
    logic [11:0] env_pc;
    int flash_lat = 0, sram_lat = 0;
    int fcnt, scnt;
    int cnt_inc, cnt_load, cnt_sreq, cnt_wr;
    logic [11:0] last_pcn;
    logic [8:0]  alu_w;

    assign pc_cur          = env_pc;
    assign flash_valid     = flash_req && (fcnt == flash_lat);
    assign flash_data      = fl[env_pc];
    assign sram_ready      = sram_req && (scnt == sram_lat);
    assign sram_rdata      = smem[sram_addr];
    assign reg_read_data_a = regs[reg_read_addr_a];
    assign reg_read_data_b = regs[reg_read_addr_b];
    assign alu_w           = alu_f(alu_opcode, alu_a, alu_b);
    assign alu_result      = alu_w[7:0];
    assign alu_carry       = alu_w[8];
    assign alu_equal       = (alu_a == alu_b);

    always @(posedge clk) begin
        if (!arst_n) begin
            env_pc <= 12'h000;
            fcnt <= 0; scnt <= 0;
            cnt_inc <= 0; cnt_load <= 0; cnt_sreq <= 0; cnt_wr <= 0;
            last_pcn <= 12'h000;
            for (int i = 0; i < 16; i++)  regs[i] <= ireg[i];
            for (int i = 0; i < 256; i++) smem[i] <= ismem[i];
        end else begin
            if (pc_load)     env_pc <= pc_next;
            else if (pc_inc) env_pc <= env_pc + 12'd1;
            if (reg_write_en)          regs[reg_write_addr] <= reg_write_data;
            if (sram_ready && sram_we) smem[sram_addr] <= sram_wdata;
            fcnt <= (flash_req && !flash_valid) ? fcnt + 1 : 0;
            scnt <= (sram_req && !sram_ready) ? scnt + 1 : 0;
            if (pc_inc)       cnt_inc  <= cnt_inc + 1;
            if (pc_load) begin
                cnt_load <= cnt_load + 1;
                last_pcn <= pc_next;
            end
            if (sram_req)     cnt_sreq <= cnt_sreq + 1;
            if (reg_write_en) cnt_wr   <= cnt_wr + 1;
        end
    end

    // ---------------- instruction-level model ----------------
    logic [7:0]  mregs [16];
    logic [7:0]  mmem  [256];
    logic [11:0] mstk  [4];
    int          msp;
    logic [11:0] mpc;
    logic        mz, mc, merr, mhalted;
    logic [7:0]  mout;
    logic [2:0]  prev_state;

    task automatic model_step();
        logic [15:0] iw;
        logic [3:0]  op, d, a, b;
        logic [8:0]  r;
        logic        z;
        iw  = {fl[mpc], fl[mpc + 12'd1]};
        mpc = mpc + 12'd2;
        op = iw[15:12]; d = iw[11:8]; a = iw[7:4]; b = iw[3:0];
        case (op)
            4'h0: begin
                if (d == 4'h1) begin
                    if (msp == 0) merr = 1'b1;
                    else begin msp--; mpc = mstk[msp]; end
                end else if (d == 4'h2) begin
                    mhalted = 1'b1;
                end else if (d == 4'h3) begin
                    if (msp == 4) merr = 1'b1;
                    else begin mstk[msp] = mpc; msp++; mpc = {mpc[11:8], a, b}; end
                end
            end
            4'h1: mregs[d] = mmem[{a, b}];
            4'h2: mmem[{a, b}] = mregs[d];
            4'h3: mpc = iw[11:0];
            4'h4: if (mz) mpc = iw[11:0];
            4'h5: if (mc) mpc = iw[11:0];
            4'h6: begin
                if (bootstrapping) begin mregs[d] = fl[mpc]; mpc = mpc + 12'd1; end
                else mregs[d] = in_gpio;
            end
            4'h7: mout = mregs[d];
            default: begin
                z = (mregs[a] == mregs[b]);
                r = alu_f(op[2:0], mregs[a], mregs[b]);
                mregs[d] = r[7:0];
                mz = z;
                mc = r[8];
            end
        endcase
    endtask

    // Compare process: architectural state after every retired instruction,
    // and request silence on every HALT cycle
    always @(negedge clk) begin
        int nr, nm;
        if (!arst_n) begin
            for (int i = 0; i < 16; i++)  mregs[i] = ireg[i];
            for (int i = 0; i < 256; i++) mmem[i]  = ismem[i];
            msp = 0; mpc = 12'h000; mz = 1'b0; mc = 1'b0;
            merr = 1'b0; mhalted = 1'b0; mout = 8'h00;
            prev_state = 3'd0;
        end else begin
            if ((prev_state == 3'd2 || prev_state == 3'd3) && (state == 3'd0 || state == 3'd4)) begin
                model_step();
                nr = 0; nm = 0;
                for (int i = 0; i < 16; i++)  if (regs[i] !== mregs[i]) nr++;
                for (int i = 0; i < 256; i++) if (smem[i] !== mmem[i])  nm++;
                chk("retire_pc", 32'(env_pc), 32'(mpc));
                chk("retire_regs_diff", 32'(nr), 32'd0);
                chk("retire_sram_diff", 32'(nm), 32'd0);
                chk("retire_out_gpio", 32'(out_gpio), 32'(mout));
                chk("retire_stack_err", 32'(stack_err), 32'(merr));
                chk("retire_halted", 32'(halted), 32'(mhalted));
            end
            if (state == 3'd4) begin
                chk("halt_flash_req", 32'(flash_req), 32'd0);
                chk("halt_sram_req", 32'(sram_req), 32'd0);
                chk("halt_halted", 32'(halted), 32'(mhalted));
                if (resume) mhalted = 1'b0;
            end
            prev_state = state;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_env();
        for (int i = 0; i < 4096; i++) fl[i] = 8'h00;
        for (int i = 0; i < 16; i++)   ireg[i] = 8'h00;
        for (int i = 0; i < 256; i++)  ismem[i] = 8'h00;
        flash_lat = 0; sram_lat = 0;
        bootstrapping = 1'b0; in_gpio = 8'h00; resume = 1'b0;
    endtask

    task automatic put(input logic [11:0] addr, input logic [15:0] w);
        fl[addr]         = w[15:8];
        fl[addr + 12'd1] = w[7:0];
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    task automatic wait_halt(input string nm);
        int n;
        n = 0;
        while (!halted && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 32'(halted), 32'd1);
    endtask

    task automatic chk_zero(input string nm);
        logic [101:0] v;
        v = {flash_req, pc_inc, pc_load, pc_next, reg_read_addr_a, reg_read_addr_b,
             reg_write_en, reg_write_addr, reg_write_data, alu_opcode, alu_a, alu_b,
             sram_req, sram_we, sram_addr, sram_wdata, out_gpio, halted, stack_err,
             state, instruction};
        chk(nm, 32'(|v), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n;
        clear_env();
        #1;
        chk_zero("reset_outputs_zero");
        do_reset();

        // JMP 0x123 with two idle cycles before each flash byte, then HALT/resume
        clear_env();
        flash_lat = 2;
        put(12'h000, 16'h3123);
        put(12'h123, 16'h0200);
        put(12'h125, 16'h0000);
        put(12'h127, 16'h0200);
        do_reset();
        wait_halt("jmp_halt_reached");
        chk("jmp_pc_inc_pulses", 32'(cnt_inc), 32'd4);
        chk("jmp_pc_load_pulses", 32'(cnt_load), 32'd1);
        chk("jmp_pc_next", 32'(last_pcn), 32'h123);
        chk("jmp_env_pc", 32'(env_pc), 32'h125);
        repeat (4) @(posedge clk);
        #1 resume = 1'b1;
        @(posedge clk);
        #1 resume = 1'b0;
        chk("resume_left_halt", 32'(halted), 32'd0);
        wait_halt("resume_halt_again");
        chk("resume_env_pc", 32'(env_pc), 32'h129);

        // ADD sets carry, BC taken, LOAD keeps C, BEQ/BC on latched flags
        clear_env();
        ireg[1] = 8'hF0; ireg[2] = 8'h20; ismem[0] = 8'h33;
        put(12'h000, 16'h8312);
        put(12'h002, 16'h5040);
        put(12'h040, 16'h1400);
        put(12'h042, 16'h5050);
        put(12'h050, 16'h4060);
        put(12'h052, 16'h9511);
        put(12'h054, 16'h4070);
        put(12'h070, 16'h5080);
        put(12'h072, 16'h0200);
        do_reset();
        wait_halt("flags_halt_reached");
        chk("flags_r3_sum", 32'(regs[3]), 32'h10);
        chk("flags_r4_load", 32'(regs[4]), 32'h33);
        chk("flags_r5_sub", 32'(regs[5]), 32'h00);
        chk("flags_env_pc", 32'(env_pc), 32'h074);

        // LOAD r3,0x5A with ready on the third request cycle, then STORE r3
        clear_env();
        sram_lat = 2;
        ismem[8'h5A] = 8'hC3;
        put(12'h000, 16'h135A);
        put(12'h002, 16'h2377);
        put(12'h004, 16'h0200);
        do_reset();
        wait_halt("mem_halt_reached");
        chk("mem_sram_req_cycles", 32'(cnt_sreq), 32'd6);
        chk("mem_reg_writes", 32'(cnt_wr), 32'd1);
        chk("mem_r3", 32'(regs[3]), 32'hC3);
        chk("mem_store", 32'(smem[8'h77]), 32'hC3);

        // Five nested CALLs (fifth overflows), five RETs (fifth underflows)
        clear_env();
        put(12'h000, 16'h0310);
        put(12'h010, 16'h0320);
        put(12'h020, 16'h0330);
        put(12'h030, 16'h0340);
        put(12'h040, 16'h0350);
        put(12'h042, 16'h0100);
        put(12'h032, 16'h0100);
        put(12'h022, 16'h0100);
        put(12'h012, 16'h0100);
        put(12'h002, 16'h0100);
        put(12'h004, 16'h0200);
        do_reset();
        wait_halt("stack_halt_reached");
        chk("stack_env_pc", 32'(env_pc), 32'h006);
        chk("stack_err_set", 32'(stack_err), 32'd1);
        chk("stack_pc_loads", 32'(cnt_load), 32'd8);

        // OUT r2 held over NOPs; plain IN from in_gpio
        clear_env();
        ireg[2] = 8'hA5; in_gpio = 8'h3C;
        put(12'h000, 16'h7200);
        put(12'h002, 16'h0000);
        put(12'h004, 16'h0000);
        put(12'h006, 16'h0700);
        put(12'h008, 16'h6600);
        put(12'h00A, 16'h0200);
        do_reset();
        wait_halt("gpio_halt_reached");
        chk("gpio_out_held", 32'(out_gpio), 32'hA5);
        chk("gpio_in_r6", 32'(regs[6]), 32'h3C);
        chk("gpio_env_pc", 32'(env_pc), 32'h00C);

        // Boot IN r1 takes its byte from flash
        clear_env();
        bootstrapping = 1'b1; flash_lat = 1; in_gpio = 8'h11;
        fl[0] = 8'h61; fl[1] = 8'h00; fl[2] = 8'h7E; fl[3] = 8'h02; fl[4] = 8'h00;
        do_reset();
        wait_halt("boot_halt_reached");
        chk("boot_r1", 32'(regs[1]), 32'h7E);
        chk("boot_pc_inc_pulses", 32'(cnt_inc), 32'd5);
        chk("boot_env_pc", 32'(env_pc), 32'h005);

        // Reset asserted while waiting on SRAM
        clear_env();
        sram_lat = 20; ismem[8'h12] = 8'h99;
        put(12'h000, 16'h1512);
        put(12'h002, 16'h0200);
        do_reset();
        n = 0;
        while (state != 3'd3 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("memwait_reached", 32'(state), 32'd3);
        chk("memwait_sram_req", 32'(sram_req), 32'd1);
        #2 arst_n = 1'b0;
        #1;
        chk_zero("memwait_reset_outputs_zero");
        sram_lat = 0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        wait_halt("after_reset_halt_reached");
        chk("after_reset_r5", 32'(regs[5]), 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
